// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ID stage: decode, operand capture, load-use stall, flush; optional DECODE_WB_BYPASS_EN write-back bypass
module decode_stage #(
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    output logic [REG_AW-1:0]  srcreg1,
    output logic [REG_AW-1:0]  srcreg2,
    input  logic [DATA_W-1:0]  rdata1,
    input  logic [DATA_W-1:0]  rdata2,
`ifdef DECODE_WB_BYPASS_EN
    input  logic               wb_write,
    input  logic [REG_AW-1:0]  wb_dest,
    input  logic [DATA_W-1:0]  wb_data,
`endif
    input  logic               flush,
    input  logic               ex_ready,
    output logic               ex_valid,
    output logic [3:0]         ex_op,
    output logic [REG_AW-1:0]  ex_rd,
    output logic [DATA_W-1:0]  ex_a,
    output logic [DATA_W-1:0]  ex_b,
    output logic [DATA_W-1:0]  ex_imm,
    output logic               ex_we,
    output logic               ex_mem_rd,
    output logic               ex_mem_wr,
    output logic               ex_illegal
);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_ADDI  = 4'd6;
    localparam logic [3:0] OP_LDI   = 4'd7;
    localparam logic [3:0] OP_LOAD  = 4'd8;
    localparam logic [3:0] OP_STORE = 4'd9;
    localparam logic [3:0] OP_BEQ   = 4'd10;
    localparam logic [3:0] OP_JMP   = 4'd11;

    typedef struct packed {
        logic              valid;
        logic [3:0]        op;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
        logic              we;
        logic              mem_rd;
        logic              mem_wr;
        logic              illegal;
    } idex_t;

    idex_t idex_q;
    idex_t idex_d;
    idex_t dec;

    logic              uses_src1;
    logic              uses_src2;
    logic              src2_is_rd_field;
    logic              hazard;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic [DATA_W-1:0] imm_sx6;
    logic [DATA_W-1:0] imm_zx8;

    assign imm_sx6 = {{(DATA_W-6){in_instr[5]}}, in_instr[5:0]};
    assign imm_zx8 = DATA_W'(in_instr[7:0]);

    // Decode the opcode into control bits, immediate and which register sources it really reads
    always_comb begin
        dec              = '0;
        uses_src1        = 1'b0;
        uses_src2        = 1'b0;
        src2_is_rd_field = 1'b0;
        dec.valid        = 1'b1;
        dec.op           = in_instr[15:12];
        dec.rd           = in_instr[11:9];
        dec.a            = opnd_a;
        dec.b            = opnd_b;
        case (in_instr[15:12])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                uses_src1 = 1'b1;
                uses_src2 = 1'b1;
                dec.we    = 1'b1;
            end
            OP_ADDI: begin
                uses_src1 = 1'b1;
                dec.we    = 1'b1;
                dec.imm   = imm_sx6;
            end
            OP_LDI: begin
                dec.we  = 1'b1;
                dec.imm = imm_zx8;
            end
            OP_LOAD: begin
                uses_src1  = 1'b1;
                dec.we     = 1'b1;
                dec.mem_rd = 1'b1;
                dec.imm    = imm_sx6;
            end
            OP_STORE: begin
                uses_src1        = 1'b1;
                uses_src2        = 1'b1;
                src2_is_rd_field = 1'b1;
                dec.mem_wr       = 1'b1;
                dec.imm          = imm_sx6;
            end
            OP_BEQ: begin
                uses_src1        = 1'b1;
                uses_src2        = 1'b1;
                src2_is_rd_field = 1'b1;
                dec.imm          = imm_sx6;
            end
            OP_JMP: begin
                dec.imm = imm_zx8;
            end
            OP_NOP: begin
                dec.rd = '0;
            end
            default: begin
                // Opcodes 12-15 travel down the pipe as a flagged NOP
                dec.op      = OP_NOP;
                dec.rd      = '0;
                dec.illegal = 1'b1;
            end
        endcase
    end

    assign srcreg1 = in_instr[8:6];
    assign srcreg2 = src2_is_rd_field ? in_instr[11:9] : in_instr[5:3];

    // Pick operand sources, optionally forwarding a same-cycle register file write
    always_comb begin
        opnd_a = rdata1;
        opnd_b = rdata2;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_write && (wb_dest == srcreg1)) opnd_a = wb_data;
        if (wb_write && (wb_dest == srcreg2)) opnd_b = wb_data;
`endif
    end

    // A load in ID/EX whose destination feeds this instruction must be let through one bubble first
    always_comb begin
        hazard = idex_q.valid && idex_q.mem_rd &&
                 ((uses_src1 && (idex_q.rd == srcreg1)) ||
                  (uses_src2 && (idex_q.rd == srcreg2)));
        in_ready = flush || (ex_ready && !hazard);
    end

    // ID/EX next value: flush beats stall; a hazard or missing input inserts a bubble
    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d = '0;
        end else if (ex_ready) begin
            if (in_valid && !hazard) idex_d = dec;
            else                     idex_d = '0;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) idex_q <= '0;
        else        idex_q <= idex_d;
    end

    assign ex_valid   = idex_q.valid;
    assign ex_op      = idex_q.op;
    assign ex_rd      = idex_q.rd;
    assign ex_a       = idex_q.a;
    assign ex_b       = idex_q.b;
    assign ex_imm     = idex_q.imm;
    assign ex_we      = idex_q.we;
    assign ex_mem_rd  = idex_q.mem_rd;
    assign ex_mem_wr  = idex_q.mem_wr;
    assign ex_illegal = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic [2:0]  srcreg1, srcreg2;
    logic [7:0]  rdata1, rdata2;
    logic        flush, ex_ready;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [2:0]  ex_rd;
    logic [7:0]  ex_a, ex_b, ex_imm;
    logic        ex_we, ex_mem_rd, ex_mem_wr, ex_illegal;
`ifdef DECODE_WB_BYPASS_EN
    logic        wb_write = 1'b0;
    logic [2:0]  wb_dest = '0;
    logic [7:0]  wb_data = '0;
`endif

    decode_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .srcreg1(srcreg1), .srcreg2(srcreg2), .rdata1(rdata1), .rdata2(rdata2),
`ifdef DECODE_WB_BYPASS_EN
        .wb_write(wb_write), .wb_dest(wb_dest), .wb_data(wb_data),
`endif
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_we(ex_we), .ex_mem_rd(ex_mem_rd),
        .ex_mem_wr(ex_mem_wr), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [3:0] op;
        logic [2:0] rd;
        logic [7:0] a, b, imm;
        logic       we, mem_rd, mem_wr, illegal;
    } ex_t;

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  r1, r2;
        logic [2:0]  s1, s2;
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [7:0]  imm;
        logic        we, mrd, mwr, ill;
    } vec_t;

    int  n_checks = 0;
    int  n_fail   = 0;
    ex_t exp_st;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic ex_t zero_ex();
        ex_t e;
        e.valid = 0; e.op = 0; e.rd = 0; e.a = 0; e.b = 0; e.imm = 0;
        e.we = 0; e.mem_rd = 0; e.mem_wr = 0; e.illegal = 0;
        return e;
    endfunction

    function automatic bit reads_a(input logic [15:0] i);
        int op = int'(i[15:12]);
        return (op >= 1 && op <= 6) || op == 8 || op == 9 || op == 10;
    endfunction

    function automatic bit reads_b(input logic [15:0] i);
        int op = int'(i[15:12]);
        return (op >= 1 && op <= 5) || op == 9 || op == 10;
    endfunction

    function automatic logic [2:0] m_src2(input logic [15:0] i);
        int op = int'(i[15:12]);
        return (op == 9 || op == 10) ? i[11:9] : i[5:3];
    endfunction

    function automatic ex_t model_decode(input logic [15:0] i, input logic [7:0] a, input logic [7:0] b);
        ex_t e = zero_ex();
        int  op = int'(i[15:12]);
        int  s6 = int'(i[5:0]);
        if (s6 >= 32) s6 -= 64;
        e.valid = 1; e.a = a; e.b = b;
        if (op >= 12) begin
            e.illegal = 1;
            return e;
        end
        e.op     = 4'(op);
        e.rd     = (op == 0) ? 3'd0 : i[11:9];
        e.we     = (op >= 1 && op <= 8);
        e.mem_rd = (op == 8);
        e.mem_wr = (op == 9);
        if (op == 6 || op == 8 || op == 9 || op == 10) e.imm = 8'(s6);
        if (op == 7 || op == 11) e.imm = i[7:0];
        return e;
    endfunction

    task automatic check_ex(input string tag);
        chk({tag, ".ex_valid"},   ex_valid,   exp_st.valid);
        chk({tag, ".ex_op"},      ex_op,      exp_st.op);
        chk({tag, ".ex_rd"},      ex_rd,      exp_st.rd);
        chk({tag, ".ex_a"},       ex_a,       exp_st.a);
        chk({tag, ".ex_b"},       ex_b,       exp_st.b);
        chk({tag, ".ex_imm"},     ex_imm,     exp_st.imm);
        chk({tag, ".ex_we"},      ex_we,      exp_st.we);
        chk({tag, ".ex_mem_rd"},  ex_mem_rd,  exp_st.mem_rd);
        chk({tag, ".ex_mem_wr"},  ex_mem_wr,  exp_st.mem_wr);
        chk({tag, ".ex_illegal"}, ex_illegal, exp_st.illegal);
    endtask

    // One clock: drive inputs, check combinational outputs at negedge, check ID/EX after posedge
    task automatic step(input string tag, input logic v, input logic [15:0] ins, input logic [7:0] r1,
                        input logic [7:0] r2, input logic fl, input logic er);
        bit         hz;
        logic [7:0] a, b;
        ex_t        nxt;
        in_valid = v; in_instr = ins; rdata1 = r1; rdata2 = r2; flush = fl; ex_ready = er;
        @(negedge clk);
        hz = exp_st.valid && exp_st.mem_rd &&
             ((reads_a(ins) && exp_st.rd == ins[8:6]) || (reads_b(ins) && exp_st.rd == m_src2(ins)));
        chk({tag, ".srcreg1"},  srcreg1,  ins[8:6]);
        chk({tag, ".srcreg2"},  srcreg2,  m_src2(ins));
        chk({tag, ".in_ready"}, in_ready, fl || (er && !hz));
        a = r1; b = r2;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_write && wb_dest == ins[8:6])     a = wb_data;
        if (wb_write && wb_dest == m_src2(ins))  b = wb_data;
`endif
        if (fl)            nxt = zero_ex();
        else if (!er)      nxt = exp_st;
        else if (hz || !v) nxt = zero_ex();
        else               nxt = model_decode(ins, a, b);
        @(posedge clk);
        #1;
        exp_st = nxt;
        check_ex(tag);
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{16'h1650, 8'd42,  8'd99,  3'd1, 3'd2, 4'd1,  3'd3, 8'h00, 1, 0, 0, 0}; // ADD r3,r1,r2
        tbl[1] = '{16'h6DFF, 8'd7,   8'd8,   3'd7, 3'd7, 4'd6,  3'd6, 8'hFF, 1, 0, 0, 0}; // ADDI r6,r7,-1
        tbl[2] = '{16'h9ABC, 8'd20,  8'd55,  3'd2, 3'd5, 4'd9,  3'd5, 8'hFC, 0, 0, 1, 0}; // STORE r5,[r2-4]
        tbl[3] = '{16'h7480, 8'd1,   8'd2,   3'd2, 3'd0, 4'd7,  3'd2, 8'h80, 1, 0, 0, 0}; // LDI r2,0x80
        tbl[4] = '{16'h8283, 8'd3,   8'd4,   3'd2, 3'd0, 4'd8,  3'd1, 8'h03, 1, 1, 0, 0}; // LOAD r1,[r2+3]
        tbl[5] = '{16'hA9A0, 8'd9,   8'd10,  3'd6, 3'd4, 4'd10, 3'd4, 8'hE0, 0, 0, 0, 0}; // BEQ r6,r4,-32
        tbl[6] = '{16'hE123, 8'd11,  8'd12,  3'd4, 3'd4, 4'd0,  3'd0, 8'h00, 0, 0, 0, 1}; // illegal 0xE
        tbl[7] = '{16'hB07F, 8'd13,  8'd14,  3'd1, 3'd7, 4'd11, 3'd0, 8'h7F, 0, 0, 0, 0}; // JMP 0x7F
        tbl[8] = '{16'h0000, 8'd15,  8'd16,  3'd0, 3'd0, 4'd0,  3'd0, 8'h00, 0, 0, 0, 0}; // NOP
        tbl[9] = '{16'h5E00, 8'hAA,  8'h55,  3'd0, 3'd0, 4'd5,  3'd7, 8'h00, 1, 0, 0, 0}; // XOR r7,r0,r0

        exp_st   = zero_ex();
        reset    = 1'b0;
        in_valid = 0; in_instr = '0; rdata1 = '0; rdata2 = '0; flush = 0; ex_ready = 1;
        repeat (2) @(negedge clk);
        check_ex("reset_init");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven decode vectors, each preceded by a bubble
        foreach (tbl[k]) begin
            step("tbl_bubble", 0, 16'h0000, 8'd0, 8'd0, 0, 1);
            in_instr = tbl[k].instr;
            #1;
            chk($sformatf("tbl%0d.srcreg1", k), srcreg1, tbl[k].s1);
            chk($sformatf("tbl%0d.srcreg2", k), srcreg2, tbl[k].s2);
            step($sformatf("tbl%0d_model", k), 1, tbl[k].instr, tbl[k].r1, tbl[k].r2, 0, 1);
            chk($sformatf("tbl%0d.valid", k),   ex_valid,   1'b1);
            chk($sformatf("tbl%0d.op", k),      ex_op,      tbl[k].op);
            chk($sformatf("tbl%0d.rd", k),      ex_rd,      tbl[k].rd);
            chk($sformatf("tbl%0d.a", k),       ex_a,       tbl[k].r1);
            chk($sformatf("tbl%0d.b", k),       ex_b,       tbl[k].r2);
            chk($sformatf("tbl%0d.imm", k),     ex_imm,     tbl[k].imm);
            chk($sformatf("tbl%0d.we", k),      ex_we,      tbl[k].we);
            chk($sformatf("tbl%0d.mem_rd", k),  ex_mem_rd,  tbl[k].mrd);
            chk($sformatf("tbl%0d.mem_wr", k),  ex_mem_wr,  tbl[k].mwr);
            chk($sformatf("tbl%0d.illegal", k), ex_illegal, tbl[k].ill);
        end

        // Load-use: exactly one bubble, then the dependent ADD issues
        step("lu_bubble", 0, 16'h0000, 8'd0, 8'd0, 0, 1);
        step("lu_load", 1, 16'h8283, 8'd30, 8'd0, 0, 1);
        in_instr = 16'h1868; in_valid = 1;
        #1;
        chk("lu_stall_ready", in_ready, 1'b0);
        step("lu_stall", 1, 16'h1868, 8'd10, 8'd20, 0, 1);
        chk("lu_bubble_valid", ex_valid, 1'b0);
        chk("lu_bubble_mrd", ex_mem_rd, 1'b0);
        step("lu_issue", 1, 16'h1868, 8'd10, 8'd20, 0, 1);
        chk("lu_issue_valid", ex_valid, 1'b1);
        chk("lu_issue_rd", ex_rd, 3'd4);
        step("lu_load2", 1, 16'h8283, 8'd30, 8'd0, 0, 1);
        in_instr = 16'h6DFF;
        #1;
        chk("lu_nodep_ready", in_ready, 1'b1);
        step("lu_addi", 1, 16'h6DFF, 8'd5, 8'd0, 0, 1);
        chk("lu_addi_valid", ex_valid, 1'b1);
        chk("lu_addi_imm", ex_imm, 8'hFF);

        // Hold for 3 cycles, then flush during the hold drops the presented instruction
        step("hold_bubble", 0, 16'h0000, 8'd0, 8'd0, 0, 1);
        step("hold_add", 1, 16'h1650, 8'd42, 8'd99, 0, 1);
        for (int k = 0; k < 3; k++) begin
            step("hold", 1, 16'h6DFF, 8'd5, 8'd6, 0, 0);
            chk("hold_ready", in_ready, 1'b0);
            chk("hold_op", ex_op, 4'd1);
            chk("hold_a", ex_a, 8'd42);
            chk("hold_b", ex_b, 8'd99);
            chk("hold_valid", ex_valid, 1'b1);
        end
        step("hold_flush", 1, 16'h6DFF, 8'd5, 8'd6, 1, 0);
        chk("flush_valid", ex_valid, 1'b0);
        step("after_flush", 0, 16'h6DFF, 8'd5, 8'd6, 0, 1);
        chk("flush_dropped", ex_valid, 1'b0);

        // Reset mid-stall clears ID/EX at once and leaves no pending hazard
        step("rst_load", 1, 16'h8283, 8'd1, 8'd2, 0, 1);
        in_instr = 16'h1868;
        #1;
        chk("rst_pre_stall", in_ready, 1'b0);
        reset = 1'b0;
        #1;
        exp_st = zero_ex();
        check_ex("rst_async");
        chk("rst_ready_hi", in_ready, 1'b1);
        ex_ready = 0;
        #1;
        chk("rst_ready_lo", in_ready, 1'b0);
        repeat (2) begin
            @(negedge clk);
            check_ex("rst_hold");
        end
        reset = 1'b1;
        step("rst_first", 1, 16'h1650, 8'd42, 8'd99, 0, 1);
        chk("rst_first_valid", ex_valid, 1'b1);
        chk("rst_first_a", ex_a, 8'd42);

`ifdef DECODE_WB_BYPASS_EN
        wb_write = 1; wb_dest = 3'd1; wb_data = 8'd77;
        step("byp_add", 1, 16'h1650, 8'd42, 8'd99, 0, 1);
        chk("byp_a", ex_a, 8'd77);
        chk("byp_b", ex_b, 8'd99);
        wb_write = 0;
`endif

        // Randomized traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            logic [15:0] ri;
            ri = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ri[15:12] = 4'h8;
`ifdef DECODE_WB_BYPASS_EN
            wb_write = 1'($urandom_range(0, 1));
            wb_dest  = 3'($urandom);
            wb_data  = 8'($urandom);
`endif
            step("rand", ($urandom_range(0, 3) != 0), ri, 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
